frac_ce_gen: RTL and testbench

//  Parametrised fractional clock-enable generator: NCH independent channels, each

---
 rtl/frac_ce_pkg.sv | 25 ++
 rtl/frac_ce_chan.sv | 47 ++++
 rtl/frac_ce_gen.sv | 116 +++++++++++
 tb/tb_frac_ce_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frac_ce_pkg.sv
// Shared types for the fractional clock-enable generator: FSM states, the
// latched configuration payload and the ratio validity rule.
package frac_ce_pkg;

    localparam int unsigned ACC_W_MAX = 32;
    localparam int unsigned CH_W_MAX  = 3;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [ACC_W_MAX-1:0] num;
        logic [ACC_W_MAX-1:0] den;
    } cfg_t;

    // A ratio is usable when it addresses a real channel and num/den lies in [0,1].
    function automatic logic ratio_ok(input cfg_t cfg, input int unsigned nch);
        return (cfg.den != '0) && (cfg.num <= cfg.den) && (32'(cfg.ch) < nch);
    endfunction

endpackage

// File: rtl/frac_ce_chan.sv
// One Bresenham channel: strobes ce at num/den of the clock rate, with a
// ratio load port (also clears phase) and a phase-clear port.
module frac_ce_chan #(
    parameter int unsigned      ACC_W   = 24,
    parameter logic [ACC_W-1:0] DEF_NUM = '0,
    parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(1)
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_num,
    input  logic [ACC_W-1:0] load_den,
    input  logic             clr,
    output logic             ce
);

    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum_c;
    logic             hit_c;

    // One extra bit keeps acc+num exact since acc<den and num<=den.
    assign sum_c = {1'b0, acc_q} + {1'b0, num_q};
    assign hit_c = (sum_c >= {1'b0, den_q});

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= DEF_NUM;
            den_q <= DEF_DEN;
            acc_q <= '0;
            ce    <= 1'b0;
        end else if (load) begin
            num_q <= load_num;
            den_q <= load_den;
            acc_q <= '0;
            ce    <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            ce    <= 1'b0;
        end else begin
            ce    <= hit_c;
            acc_q <= hit_c ? ACC_W'(sum_c - {1'b0, den_q}) : sum_c[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/frac_ce_gen.sv
// Multi-channel fractional clock-enable generator with run-time ratio
// reprogramming and a lock indicator that tracks ratio settling.
module frac_ce_gen
    import frac_ce_pkg::*;
#(
    parameter int unsigned            NCH         = 2,
    parameter int unsigned            ACC_W       = 24,
    parameter int unsigned            LOCK_CYCLES = 16,
    parameter logic [NCH*ACC_W-1:0]   DEF_NUM     = {24'd1, 24'd4},
    parameter logic [NCH*ACC_W-1:0]   DEF_DEN     = {24'd1, 24'd15},
    localparam int unsigned           CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             cfg_err,
    input  logic             sync,
    output logic [NCH-1:0]   ce,
    output logic             locked
);

    localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             cfg_q, cfg_d, in_cfg_c;
    logic             err_d;
    logic             accept_c;
    logic             apply_c;

    always_comb begin
        in_cfg_c     = '0;
        in_cfg_c.ch  = CH_W_MAX'(cfg_ch);
        in_cfg_c.num = ACC_W_MAX'(cfg_num);
        in_cfg_c.den = ACC_W_MAX'(cfg_den);
    end

    // Next-state: settle counting, one-cycle apply, and write acceptance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        err_d    = 1'b0;
        apply_c  = 1'b0;
        accept_c = cfg_valid && cfg_ready;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            APPLY: begin
                apply_c = 1'b1;
                state_d = SETTLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
        // cfg_ready is low in APPLY, so an accept never overrides the apply cycle.
        if (accept_c) begin
            cfg_d = in_cfg_c;
            if (ratio_ok(in_cfg_c, NCH)) begin
                state_d = APPLY;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SETTLE;
            cnt_q     <= '0;
            cfg_q     <= '0;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            cfg_ready <= (state_d != APPLY);
            locked    <= (state_d == LOCKED);
            cfg_err   <= err_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        frac_ce_chan #(
            .ACC_W   (ACC_W),
            .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
            .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
        ) u_chan (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .load     (apply_c && (cfg_q.ch == CH_W_MAX'(i))),
            .load_num (ACC_W'(cfg_q.num)),
            .load_den (ACC_W'(cfg_q.den)),
            .clr      (sync),
            .ce       (ce[i])
        );
    end

endmodule

// File: tb/tb_frac_ce_gen.sv
// Scoreboard bench for frac_ce_gen: a ratio/time reference model queues the
// expected outputs for every clock, a monitor pops and compares them.
module tb_frac_ce_gen;

    localparam int unsigned NCH   = 3;
    localparam int unsigned ACC_W = 24;
    localparam int unsigned LOCK  = 16;
    localparam int unsigned EXP_W = NCH + 3;

    logic             refclk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_err;
    logic             sync;
    logic [NCH-1:0]   ce;
    logic             locked;

    frac_ce_gen #(
        .NCH         (NCH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK),
        .DEF_NUM     ({24'd2, 24'd1, 24'd4}),
        .DEF_DEN     ({24'd5, 24'd1, 24'd15})
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_err   (cfg_err),
        .sync      (sync),
        .ce        (ce),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int n_vec = 0;
    int n_err = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Reference model state: ratio per channel, cycles since phase restart,
    // cycles since settling began, and a pending apply.
    longint unsigned m_num[NCH];
    longint unsigned m_den[NCH];
    longint unsigned m_k[NCH];
    int              m_since;
    bit              m_apply, m_ready, m_locked, m_err;
    int              p_ch;
    longint unsigned p_num, p_den;
    bit              m_acc, m_good;
    logic [NCH-1:0]  m_ce;

    function automatic bit exp_ce(input longint unsigned k, input longint unsigned n,
                                  input longint unsigned d);
        return ((k * n) / d) != (((k - 1) * n) / d);
    endfunction

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_num[0] = 4; m_den[0] = 15;
            m_num[1] = 1; m_den[1] = 1;
            m_num[2] = 2; m_den[2] = 5;
            for (int c = 0; c < NCH; c++) m_k[c] = 0;
            m_since = 0; m_apply = 0; m_ready = 0; m_locked = 0; m_err = 0;
        end else begin
            m_acc  = cfg_valid && m_ready;
            m_good = m_acc && (cfg_den != 0) && (cfg_num <= cfg_den) && (int'(cfg_ch) < NCH);
            for (int c = 0; c < NCH; c++) begin
                if (m_apply && c == p_ch) begin
                    m_num[c] = p_num; m_den[c] = p_den; m_k[c] = 0; m_ce[c] = 1'b0;
                end else if (sync) begin
                    m_k[c] = 0; m_ce[c] = 1'b0;
                end else begin
                    m_k[c]  = m_k[c] + 1;
                    m_ce[c] = exp_ce(m_k[c], m_num[c], m_den[c]);
                end
            end
            if (m_apply) begin
                m_apply = 0;
                m_since = 0;
            end else if (m_good) begin
                m_apply = 1;
                p_ch = int'(cfg_ch); p_num = cfg_num; p_den = cfg_den;
            end else begin
                m_since++;
            end
            m_err    = m_acc && !m_good;
            m_ready  = !m_apply;
            m_locked = !m_apply && (m_since >= int'(LOCK));
            exp_q.push_back({m_ce, m_locked, m_ready, m_err});
        end
    end

    // Monitor: outputs are sampled on the falling edge, away from updates.
    logic [EXP_W-1:0] got, want;
    always @(negedge refclk) begin
        got = {ce, locked, cfg_ready, cfg_err};
        if (!rst_n) begin
            n_vec++;
            if (got !== '0) begin
                n_err++;
                $display("FAIL reset_hold t=%0t got ce=%b lk=%b rdy=%b err=%b required all zero",
                         $time, ce, locked, cfg_ready, cfg_err);
            end
        end else if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty t=%0t no expected entry for got=%b", $time, got);
        end else begin
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL cycle t=%0t got ce=%b lk=%b rdy=%b err=%b required ce=%b lk=%b rdy=%b err=%b",
                         $time, ce, locked, cfg_ready, cfg_err,
                         want[EXP_W-1:3], want[2], want[1], want[0]);
            end
        end
    end

    task automatic step();
        @(negedge refclk);
        #1;
    endtask

    // Presents one write and holds it until accepted (bounded wait on cfg_ready).
    task automatic do_write(input int ch, input int num, input int den, input bit with_sync);
        int tries;
        tries = 0;
        while (cfg_ready !== 1'b1 && tries < 8) begin
            step();
            tries++;
        end
        if (tries >= 8) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout t=%0t cfg_ready=%b required 1", $time, cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_num   = ACC_W'(num);
        cfg_den   = ACC_W'(den);
        sync      = with_sync;
        step();
        cfg_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    int r, rch, rnum, rden;

    initial begin
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; sync = 1'b0;
        #1 rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(40);

        // ch0 to 3/8, then watch the settle window and the new pattern
        do_write(0, 3, 8, 1'b0);
        run(40);

        // rejected writes: zero denominator, ratio above one, missing channel
        do_write(0, 5, 0, 1'b0);
        run(3);
        do_write(1, 9, 8, 1'b0);
        run(3);
        do_write(3, 1, 2, 1'b0);
        run(20);

        // realign all accumulators mid-run
        run(5);
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(30);

        // write during SETTLE with sync on the accept, then sync during APPLY
        do_write(1, 2, 7, 1'b0);
        run(4);
        do_write(2, 5, 9, 1'b1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(30);

        // ratio extremes: never and always
        do_write(2, 0, 7, 1'b0);
        run(3);
        do_write(1, 5, 5, 1'b0);
        run(30);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                rch  = $urandom_range(0, 3);
                rden = $urandom_range(0, 40);
                rnum = (r < 3) ? $urandom_range(0, rden) : $urandom_range(0, 45);
                do_write(rch, rnum, rden, $urandom_range(0, 3) == 0);
            end else if (r < 7) begin
                sync = 1'b1;
                step();
                sync = 1'b0;
            end
            run($urandom_range(1, 12));
        end
        run(25);

        // reset in the middle of an APPLY cycle
        do_write(0, 1, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ce, locked, cfg_ready, cfg_err} !== '0) begin
            n_err++;
            $display("FAIL async_reset t=%0t got ce=%b lk=%b rdy=%b err=%b required all zero",
                     $time, ce, locked, cfg_ready, cfg_err);
        end
        run(2);
        rst_n = 1'b1;
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
